threshold_binarize: RTL and testbench

Downstream stage of the binary fully-connected accumulator. It takes one vector of signed per-neuron accumulation results and applies a per-neuron batch-norm-folded threshold to each element, producing one activation bit per neuron for the next binary layer. Comparisons run LANES neurons per cycle under a small FSM. A valid/ready handshake sits on each side, and the threshold table is programmed through a write port.

---
 rtl/threshold_binarize_pkg.sv | 17 +
 rtl/threshold_binarize_if.sv | 42 ++++
 rtl/threshold_binarize_lane.sv | 20 ++
 rtl/threshold_binarize.sv | 137 +++++++++++++
 tb/tb_threshold_binarize.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/threshold_binarize_pkg.sv
// Shared types and default sizes for the threshold_binarize stage.
// BIN_FLIP_EN (optional define) adds per-neuron output inversion.
package threshold_binarize_pkg;

   localparam int DEF_OUT_DIM = 64;
   localparam int DEF_ACC_BIT = 16;
   localparam int DEF_LANES   = 8;

   typedef logic signed [DEF_ACC_BIT-1:0] acc_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      DONE = 2'd2
   } state_e;

endpackage

// File: rtl/threshold_binarize_if.sv
// Handshake, vector and threshold-programming signals of threshold_binarize.
// BIN_FLIP_EN adds the thr_flip_i signal to both modports.
interface threshold_binarize_if
   import threshold_binarize_pkg::*;
#(
   parameter int OUT_DIM = DEF_OUT_DIM,
   parameter int ACC_BIT = DEF_ACC_BIT
);
   localparam int ADDR_W = (OUT_DIM > 1) ? $clog2(OUT_DIM) : 1;

   logic                         acc_valid_i;
   logic                         acc_ready_o;
   logic [OUT_DIM*ACC_BIT-1:0]   acc_i;
   logic                         thr_we_i;
   logic [ADDR_W-1:0]            thr_addr_i;
   logic signed [ACC_BIT-1:0]    thr_data_i;
`ifdef BIN_FLIP_EN
   logic                         thr_flip_i;
`endif
   logic                         bin_valid_o;
   logic                         bin_ready_i;
   logic [OUT_DIM-1:0]           bin_o;

   modport slave (
      input  acc_valid_i, acc_i, thr_we_i, thr_addr_i, thr_data_i,
`ifdef BIN_FLIP_EN
             thr_flip_i,
`endif
             bin_ready_i,
      output acc_ready_o, bin_valid_o, bin_o
   );

   modport master (
      output acc_valid_i, acc_i, thr_we_i, thr_addr_i, thr_data_i,
`ifdef BIN_FLIP_EN
             thr_flip_i,
`endif
             bin_ready_i,
      input  acc_ready_o, bin_valid_o, bin_o
   );

endinterface

// File: rtl/threshold_binarize_lane.sv
// Single-neuron signed threshold compare; equality yields 1.
// With BIN_FLIP_EN the result is inverted by flip_i.
module threshold_lane #(
   parameter int ACC_BIT = 16
) (
   input  logic signed [ACC_BIT-1:0] acc_i,
   input  logic signed [ACC_BIT-1:0] thr_i,
`ifdef BIN_FLIP_EN
   input  logic                      flip_i,
`endif
   output logic                      bin_o
);

`ifdef BIN_FLIP_EN
   assign bin_o = (acc_i >= thr_i) ^ flip_i;
`else
   assign bin_o = (acc_i >= thr_i);
`endif

endmodule

// File: rtl/threshold_binarize.sv
// Binarizes a vector of signed accumulations against a programmable threshold
// table, LANES neurons per cycle. Optional define BIN_FLIP_EN adds flip bits.
module threshold_binarize
   import threshold_binarize_pkg::*;
#(
   parameter int OUT_DIM = DEF_OUT_DIM,
   parameter int ACC_BIT = DEF_ACC_BIT,
   parameter int LANES   = DEF_LANES
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   threshold_binarize_if.slave  bus,
   output logic                 busy_o
);

   localparam int N     = OUT_DIM / LANES;
   localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
   localparam int IDX_W = (OUT_DIM > 1) ? $clog2(OUT_DIM) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

   state_e                     state_q, state_d;
   logic [CNT_W-1:0]           cnt_q, cnt_d;
   logic [OUT_DIM*ACC_BIT-1:0] acc_vec_q, acc_vec_d;
   logic signed [ACC_BIT-1:0]  thr_q [OUT_DIM];
   logic signed [ACC_BIT-1:0]  thr_d [OUT_DIM];
`ifdef BIN_FLIP_EN
   logic [OUT_DIM-1:0]         flip_q, flip_d;
`endif
   logic [OUT_DIM-1:0]         bin_q, bin_d;
   logic                       acc_ready_q, acc_ready_d;
   logic                       bin_valid_q, bin_valid_d;
   logic                       busy_q, busy_d;

   logic [IDX_W-1:0]           lane_idx [LANES];
   logic [LANES-1:0]           lane_bit;

   for (genvar l = 0; l < LANES; l++) begin : g_lane
      assign lane_idx[l] = IDX_W'(int'(cnt_q) * LANES + l);

      threshold_lane #(
         .ACC_BIT (ACC_BIT)
      ) u_lane (
         .acc_i  (acc_vec_q[int'(lane_idx[l]) * ACC_BIT +: ACC_BIT]),
         .thr_i  (thr_q[lane_idx[l]]),
`ifdef BIN_FLIP_EN
         .flip_i (flip_q[lane_idx[l]]),
`endif
         .bin_o  (lane_bit[l])
      );
   end

   // Table writes are only honoured in IDLE so the thresholds stay frozen per vector.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      acc_vec_d = acc_vec_q;
      thr_d     = thr_q;
`ifdef BIN_FLIP_EN
      flip_d    = flip_q;
`endif
      bin_d     = bin_q;

      unique case (state_q)
         IDLE: begin
            if (bus.thr_we_i) begin
               thr_d[bus.thr_addr_i] = bus.thr_data_i;
`ifdef BIN_FLIP_EN
               flip_d[bus.thr_addr_i] = bus.thr_flip_i;
`endif
            end
            if (bus.acc_valid_i) begin
               acc_vec_d = bus.acc_i;
               cnt_d     = '0;
               state_d   = SCAN;
            end
         end
         SCAN: begin
            for (int l = 0; l < LANES; l++) begin
               bin_d[lane_idx[l]] = lane_bit[l];
            end
            if (cnt_q == CNT_LAST) begin
               cnt_d   = '0;
               state_d = DONE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         DONE: begin
            if (bus.bin_ready_i) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      acc_ready_d = (state_d == IDLE);
      bin_valid_d = (state_d == DONE);
      busy_d      = (state_d != IDLE);
   end

   // Status outputs are registered from the next state so they carry no input paths.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         acc_vec_q   <= '0;
         thr_q       <= '{default: '0};
`ifdef BIN_FLIP_EN
         flip_q      <= '0;
`endif
         bin_q       <= '0;
         acc_ready_q <= 1'b1;
         bin_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         acc_vec_q   <= acc_vec_d;
         thr_q       <= thr_d;
`ifdef BIN_FLIP_EN
         flip_q      <= flip_d;
`endif
         bin_q       <= bin_d;
         acc_ready_q <= acc_ready_d;
         bin_valid_q <= bin_valid_d;
         busy_q      <= busy_d;
      end
   end

   assign bus.acc_ready_o = acc_ready_q;
   assign bus.bin_valid_o = bin_valid_q;
   assign bus.bin_o       = bin_q;
   assign busy_o          = busy_q;

endmodule

// File: tb/tb_threshold_binarize.sv
// Directed self-checking bench for threshold_binarize (default 64 neurons, 8 lanes).
// Expectations follow BIN_FLIP_EN when the bench is built with it.
module tb_threshold_binarize;
   import threshold_binarize_pkg::*;

   localparam int OUT_DIM = DEF_OUT_DIM;
   localparam int ACC_BIT = DEF_ACC_BIT;
   localparam int LANES   = DEF_LANES;
   localparam int AW      = $clog2(OUT_DIM);
   localparam int W       = OUT_DIM * ACC_BIT;
   localparam int LAT     = OUT_DIM / LANES + 1;

   logic clk = 1'b0;
   logic rst_n;
   logic busy;
   int   assertCount = 0;
   int   failCount   = 0;

   threshold_binarize_if #(.OUT_DIM(OUT_DIM), .ACC_BIT(ACC_BIT)) bus ();

   threshold_binarize #(
      .OUT_DIM (OUT_DIM),
      .ACC_BIT (ACC_BIT),
      .LANES   (LANES)
   ) dut (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .bus    (bus),
      .busy_o (busy)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      assertCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   task automatic writeThr(input int addr, input int data, input bit flip);
      bus.thr_we_i   = 1'b1;
      bus.thr_addr_i = AW'(addr);
      bus.thr_data_i = ACC_BIT'(data);
`ifdef BIN_FLIP_EN
      bus.thr_flip_i = flip;
`else
      if (flip) $display("[TB] flip request ignored in this build");
`endif
      @(negedge clk);
      bus.thr_we_i = 1'b0;
   endtask

   // Presents one vector at a negedge and returns the cycles until bin_valid_o is seen.
   task automatic applyStimulus(input logic [W-1:0] vec, output int lat);
      bus.acc_i       = vec;
      bus.acc_valid_i = 1'b1;
      @(negedge clk);
      bus.acc_valid_i = 1'b0;
      bus.thr_we_i    = 1'b0;
      bus.acc_i       = '0;
      lat = 1;
      while (!bus.bin_valid_o && lat < 40) begin
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic releaseVector(input string tag);
      bus.bin_ready_i = 1'b1;
      @(negedge clk);
      bus.bin_ready_i = 1'b0;
      checkOutput({tag, " ready after release"}, bus.acc_ready_o, 1);
      checkOutput({tag, " valid after release"}, bus.bin_valid_o, 0);
      checkOutput({tag, " busy after release"}, busy, 0);
   endtask

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: observed timeout expected completion");
      $fatal(1, "[TB] simulation timeout");
   end

   initial begin
      logic [W-1:0] vec;
      logic [63:0]  exp3;
      logic [63:0]  exp5;
      int           lat;
      bit           sawValid;

      bus.acc_valid_i = 1'b0;
      bus.acc_i       = '0;
      bus.thr_we_i    = 1'b0;
      bus.thr_addr_i  = '0;
      bus.thr_data_i  = '0;
`ifdef BIN_FLIP_EN
      bus.thr_flip_i  = 1'b0;
`endif
      bus.bin_ready_i = 1'b0;
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      checkOutput("reset acc_ready", bus.acc_ready_o, 1);
      checkOutput("reset bin_valid", bus.bin_valid_o, 0);
      checkOutput("reset bin", bus.bin_o, 64'h0);
      checkOutput("reset busy", busy, 0);

      // Zero thresholds with a ramp -32..31: upper half positive or zero.
      for (int k = 0; k < OUT_DIM; k++) vec[k*ACC_BIT +: ACC_BIT] = acc_t'(k - 32);
      applyStimulus(vec, lat);
      checkOutput("ramp latency", lat, LAT);
      checkOutput("ramp bin", bus.bin_o, 64'hFFFF_FFFF_0000_0000);
      checkOutput("ramp busy in done", busy, 1);
      releaseVector("ramp");

      // Equality, below-threshold, and a write landing in the handshake cycle.
      writeThr(5, -3, 1'b0);
      writeThr(6, -3, 1'b0);
      vec = '0;
      vec[5*ACC_BIT +: ACC_BIT] = acc_t'(-3);
      vec[6*ACC_BIT +: ACC_BIT] = acc_t'(-4);
      vec[7*ACC_BIT +: ACC_BIT] = acc_t'(4);
      bus.thr_we_i   = 1'b1;
      bus.thr_addr_i = AW'(7);
      bus.thr_data_i = ACC_BIT'(5);
      exp3 = 64'hFFFF_FFFF_FFFF_FF3F;
      applyStimulus(vec, lat);
      checkOutput("neg latency", lat, LAT);
      checkOutput("neg bin", bus.bin_o, exp3);
      checkOutput("equality bit5", bus.bin_o[5], 1);
      checkOutput("below bit6", bus.bin_o[6], 0);

      // Backpressure with a table write and a new vector offered mid-hold.
      for (int i = 0; i < 20; i++) begin
         bus.thr_we_i    = (i == 5);
         bus.thr_addr_i  = AW'(10);
         bus.thr_data_i  = ACC_BIT'(100);
         bus.acc_valid_i = (i == 8);
         bus.acc_i       = (i == 8) ? '1 : '0;
         @(negedge clk);
         checkOutput("hold bin", bus.bin_o, exp3);
         checkOutput("hold acc_ready", bus.acc_ready_o, 0);
         checkOutput("hold bin_valid", bus.bin_valid_o, 1);
      end
      bus.thr_we_i    = 1'b0;
      bus.acc_valid_i = 1'b0;
      releaseVector("hold");

      vec = '0;
      applyStimulus(vec, lat);
      checkOutput("readback latency", lat, LAT);
      checkOutput("readback bin", bus.bin_o, 64'hFFFF_FFFF_FFFF_FF7F);
      checkOutput("ignored write bit10", bus.bin_o[10], 1);
      releaseVector("readback");

      // Threshold 10 with flip requested, acc 12.
      writeThr(3, 10, 1'b1);
      vec = '0;
      vec[3*ACC_BIT +: ACC_BIT] = acc_t'(12);
`ifdef BIN_FLIP_EN
      exp5 = 64'hFFFF_FFFF_FFFF_FF77;
`else
      exp5 = 64'hFFFF_FFFF_FFFF_FF7F;
`endif
      applyStimulus(vec, lat);
      checkOutput("flip bin", bus.bin_o, exp5);
      checkOutput("flip bit3", bus.bin_o[3], exp5[3]);
      releaseVector("flip");

      // Reset in the third SCAN cycle clears the FSM and the table.
      vec = '1;
      bus.acc_i       = vec;
      bus.acc_valid_i = 1'b1;
      @(negedge clk);
      bus.acc_valid_i = 1'b0;
      repeat (2) @(negedge clk);
      checkOutput("scan busy", busy, 1);
      rst_n = 1'b0;
      #1;
      checkOutput("midscan reset busy", busy, 0);
      checkOutput("midscan reset ready", bus.acc_ready_o, 1);
      @(negedge clk);
      rst_n = 1'b1;
      checkOutput("post reset valid", bus.bin_valid_o, 0);
      sawValid = 1'b0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (bus.bin_valid_o) sawValid = 1'b1;
      end
      checkOutput("valid never rose", sawValid, 0);

      applyStimulus(vec, lat);
      checkOutput("cleared latency", lat, LAT);
      checkOutput("cleared table bin", bus.bin_o, 64'h0);
      releaseVector("cleared");

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
